// File: rtl/hw_imp_accelerator.sv
// CRC-32 (IEEE 802.3, reflected) accelerator behind a single-bit-address
// Avalon-MM slave, with a bit-serial engine that absorbs one bit per cycle.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   reset        synchronous active-low reset
//   address      0 = CTRL (write) / RESULT (read), 1 = DATA (write) / COUNT (read)
//   write        write strobe, honoured only when waitrequest is low
//   writedata    32-bit write data
//   read         read strobe
//   readdata     ~crc or count while read is high, zero otherwise
//   waitrequest  high while the engine is busy and a strobe is present

module hw_imp_accelerator (
   input  logic        clk,
   input  logic        reset,
   input  logic        address,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        read,
   output logic [31:0] readdata,
   output logic        waitrequest
);

   localparam logic [31:0] POLY = 32'hEDB8_8320;
   localparam logic [31:0] INIT = 32'hFFFF_FFFF;

   logic [31:0] crc;
   logic [31:0] count;
   logic        busy;
   logic [4:0]  bitcnt;

   logic [31:0] crc_shift;
   logic        accept;

   // One step of the reflected LFSR: the LSB leaves first.
   always_comb begin
      crc_shift = {1'b0, crc[31:1]};
      if (crc[0]) begin
         crc_shift = crc_shift ^ POLY;
      end
   end

   assign waitrequest = busy & (read | write);

   // A write is taken only while idle, so a CTRL clear can never land
   // on a partially absorbed word.
   assign accept = write & ~busy;

   always_comb begin
      readdata = 32'h0;
      if (read) begin
         readdata = address ? count : ~crc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         crc    <= INIT;
         count  <= 32'h0;
         busy   <= 1'b0;
         bitcnt <= 5'd0;
      end else if (busy) begin
         crc    <= crc_shift;
         bitcnt <= bitcnt + 5'd1;
         // Last of the 32 shifts: bitcnt wraps to zero here.
         if (bitcnt == 5'd31) begin
            busy <= 1'b0;
         end
      end else if (accept) begin
         if (address) begin
            crc    <= crc ^ writedata;
            busy   <= 1'b1;
            bitcnt <= 5'd0;
            count  <= count + 32'd1;
         end else if (writedata[0]) begin
            crc   <= INIT;
            count <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_hw_imp_accelerator.sv
// Self-checking bench for hw_imp_accelerator: a byte-stream CRC-32 model
// checked every cycle, plus directed transactions with literal expectations.

module tb_hw_imp_accelerator;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   hw_imp_accelerator dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .write       (write),
      .writedata   (writedata),
      .read        (read),
      .readdata    (readdata),
      .waitrequest (waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Standard byte-oriented CRC-32 over everything absorbed since clear.
   function automatic logic [31:0] crc32(input byte_q_t q);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   // Model: byte stream, word count, cycles left before the engine idles.
   byte_q_t     m_bytes;
   logic [31:0] m_count;
   int          m_busy;

   always @(posedge clk) begin
      if (!reset) begin
         m_bytes.delete();
         m_count = 32'h0;
         m_busy  = 0;
      end else if (m_busy > 0) begin
         m_busy--;
      end else if (write) begin
         if (address) begin
            for (int b = 0; b < 4; b++) begin
               m_bytes.push_back(writedata[8*b +: 8]);
            end
            m_count = m_count + 32'd1;
            m_busy  = 32;
         end else if (writedata[0]) begin
            m_bytes.delete();
            m_count = 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("waitrequest", {31'h0, waitrequest},
             {31'h0, (m_busy > 0) && (read || write)});
         if (!read) begin
            chk("readdata_idle", readdata, 32'h0);
         end else if (m_busy == 0) begin
            chk("readdata_model", readdata,
                address ? m_count : crc32(m_bytes));
         end
      end
   end

   task automatic bus_write(input logic a, input logic [31:0] d,
                            output int stall);
      stall     = 0;
      address   = a;
      writedata = d;
      write     = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!waitrequest) break;
         stall++;
      end
      if (stall >= 100) chk("write_timeout", 32'(stall), 32'd0);
      @(posedge clk);
      #1 write = 1'b0;
   endtask

   task automatic bus_read(input logic a, output logic [31:0] d,
                           output int stall);
      stall   = 0;
      address = a;
      read    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!waitrequest) break;
         stall++;
      end
      if (stall >= 100) chk("read_timeout", 32'(stall), 32'd0);
      d = readdata;
      @(posedge clk);
      #1 read = 1'b0;
   endtask

   logic [31:0] rd;
   int          st;

   initial begin
      reset     = 1'b0;
      address   = 1'b0;
      write     = 1'b0;
      writedata = 32'h0;
      read      = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      started  = 1'b1;

      // Reset state
      bus_read(1'b0, rd, st);
      chk("rst_result", rd, 32'h0);
      chk("rst_result_stall", 32'(st), 32'd0);
      bus_read(1'b1, rd, st);
      chk("rst_count", rd, 32'h0);

      // One zero word, read issued the cycle after acceptance
      bus_write(1'b1, 32'h0, st);
      bus_read(1'b0, rd, st);
      chk("zero_stall", 32'(st), 32'd32);
      chk("zero_crc", rd, 32'h2144_DF1C);
      bus_read(1'b1, rd, st);
      chk("zero_count", rd, 32'd1);

      // Clear, then "1234"
      bus_write(1'b0, 32'h1, st);
      bus_read(1'b1, rd, st);
      chk("clear_count", rd, 32'd0);
      bus_write(1'b1, 32'h3433_3231, st);
      bus_read(1'b0, rd, st);
      chk("abc_crc", rd, 32'h9BE3_E0A3);

      // Back-to-back DATA writes: second stalls and is taken once
      bus_write(1'b0, 32'h1, st);
      bus_write(1'b1, 32'h1111_1111, st);
      bus_write(1'b1, 32'h2222_2222, st);
      chk("b2b_stall", 32'(st), 32'd32);
      bus_read(1'b1, rd, st);
      chk("b2b_count", rd, 32'd2);

      // Reset during processing discards the word
      bus_write(1'b0, 32'h1, st);
      bus_write(1'b1, 32'h0, st);
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      bus_read(1'b0, rd, st);
      chk("abort_stall", 32'(st), 32'd0);
      chk("abort_crc", rd, 32'h0);
      bus_read(1'b1, rd, st);
      chk("abort_count", rd, 32'd0);

      // CTRL write with bit0 clear changes nothing
      bus_write(1'b1, 32'h0, st);
      bus_write(1'b0, 32'hFFFF_FFFE, st);
      chk("ctrl_nop_stall", 32'(st), 32'd32);
      bus_read(1'b0, rd, st);
      chk("ctrl_nop_crc", rd, 32'h2144_DF1C);
      bus_read(1'b1, rd, st);
      chk("ctrl_nop_count", rd, 32'd1);

      // Simultaneous read and write: read sees the pre-write count
      address   = 1'b1;
      writedata = 32'h1234_5678;
      read      = 1'b1;
      write     = 1'b1;
      @(negedge clk);
      chk("rw_wait", {31'h0, waitrequest}, 32'h0);
      chk("rw_readdata", readdata, 32'd1);
      @(posedge clk);
      #1 begin
         read  = 1'b0;
         write = 1'b0;
      end
      bus_read(1'b1, rd, st);
      chk("rw_count", rd, 32'd2);
      chk("rw_stall", 32'(st), 32'd32);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
